// File: rtl/nonoverlap_clock_gen.sv
// Two-phase non-overlapping clock generator with programmable phase and dead-time widths.
// Optional early-falling phases phi1e/phi2e are built when NOVL_EARLY_PHASE_EN is defined.
module nonoverlap_clock_gen #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PCNT_W = 16
`ifdef NOVL_EARLY_PHASE_EN
  ,
  parameter int unsigned EARLY_LEN = 1
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  phi1_len,
  input  logic [CNT_W-1:0]  phi2_len,
  input  logic [CNT_W-1:0]  dead_len,
  output logic              phi1,
  output logic              phi2,
  output logic              busy,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_cnt
`ifdef NOVL_EARLY_PHASE_EN
  ,
  output logic              phi1e,
  output logic              phi2e
`endif
);

  localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PCNT_W-1:0] PcntOne = {{(PCNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StPhi1,
    StDead12,
    StPhi2,
    StDead21
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   p1_q, p1_d;
  logic [CNT_W-1:0]   p2_q, p2_d;
  logic [CNT_W-1:0]   d_q, d_d;
  logic [PCNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic               phi1_q, phi2_q, period_done_q;
  logic               cnt_zero;

  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CntOne : v;
  endfunction

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    d_d          = d_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StPhi1;
          p1_d    = clamp1(phi1_len);
          p2_d    = clamp1(phi2_len);
          d_d     = clamp1(dead_len);
          cnt_d   = clamp1(phi1_len) - CntOne;
        end
      end
      StPhi1: begin
        if (cnt_zero) begin
          state_d = StDead12;
          cnt_d   = d_q - CntOne;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDead12: begin
        if (cnt_zero) begin
          state_d = StPhi2;
          cnt_d   = p2_q - CntOne;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPhi2: begin
        if (cnt_zero) begin
          state_d = StDead21;
          cnt_d   = d_q - CntOne;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDead21: begin
        if (cnt_zero) begin
          period_cnt_d = period_cnt_q + PcntOne;
          // A late enable keeps running; otherwise park in idle only after the full dead time.
          if (enable) begin
            state_d = StPhi1;
            p1_d    = clamp1(phi1_len);
            p2_d    = clamp1(phi2_len);
            d_d     = clamp1(dead_len);
            cnt_d   = clamp1(phi1_len) - CntOne;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      d_q           <= '0;
      period_cnt_q  <= '0;
      phi1_q        <= 1'b0;
      phi2_q        <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      d_q           <= d_d;
      period_cnt_q  <= period_cnt_d;
      // Outputs are decoded from the next state so each flop matches the state it reflects.
      phi1_q        <= (state_d == StPhi1);
      phi2_q        <= (state_d == StPhi2);
      period_done_q <= (state_d == StDead21) && (cnt_d == '0);
    end
  end

  assign phi1        = phi1_q;
  assign phi2        = phi2_q;
  assign busy        = (state_q != StIdle);
  assign period_done = period_done_q;
  assign period_cnt  = period_cnt_q;

`ifdef NOVL_EARLY_PHASE_EN
  localparam logic [CNT_W-1:0] EarlyLen = EARLY_LEN[CNT_W-1:0];

  logic phi1e_q, phi2e_q;
  logic phi1e_d, phi2e_d;

  // The entry cycle is always high, so short phases still get a one-cycle early pulse.
  always_comb begin
    phi1e_d = (state_d == StPhi1) && ((state_q != StPhi1) || (cnt_d >= EarlyLen));
    phi2e_d = (state_d == StPhi2) && ((state_q != StPhi2) || (cnt_d >= EarlyLen));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi1e_q <= 1'b0;
      phi2e_q <= 1'b0;
    end else begin
      phi1e_q <= phi1e_d;
      phi2e_q <= phi2e_d;
    end
  end

  assign phi1e = phi1e_q;
  assign phi2e = phi2e_q;
`endif

endmodule

// File: tb/tb_nonoverlap_clock_gen.sv
// Self-checking bench for nonoverlap_clock_gen: table vectors, corner sequences and a
// randomized run against a period-position reference model.
module tb_nonoverlap_clock_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  phi1_len, phi2_len, dead_len;
  logic        phi1, phi2, busy, period_done;
  logic [15:0] period_cnt;
`ifdef NOVL_EARLY_PHASE_EN
  logic        phi1e, phi2e;
  localparam int EL = 1;
`endif

  int checks = 0;
  int failures = 0;

  nonoverlap_clock_gen #(
    .CNT_W (8),
    .PCNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .phi1_len   (phi1_len),
    .phi2_len   (phi2_len),
    .dead_len   (dead_len),
    .phi1       (phi1),
    .phi2       (phi2),
    .busy       (busy),
    .period_done(period_done),
    .period_cnt (period_cnt)
`ifdef NOVL_EARLY_PHASE_EN
    ,
    .phi1e      (phi1e),
    .phi2e      (phi2e)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: position within the current period plus captured clamped lengths.
  int m_run = 0, m_pos = 0, m_p1 = 1, m_p2 = 1, m_d = 1, m_pcnt = 0;

  function automatic int clampv(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int per;
    per = m_p1 + m_p2 + 2 * m_d;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pcnt = 0;
    end else if (m_run == 0) begin
      if (enable) begin
        m_run = 1; m_pos = 0;
        m_p1 = clampv(int'(phi1_len)); m_p2 = clampv(int'(phi2_len)); m_d = clampv(int'(dead_len));
      end
    end else if (m_pos == per - 1) begin
      m_pcnt = (m_pcnt + 1) % 65536;
      if (enable) begin
        m_pos = 0;
        m_p1 = clampv(int'(phi1_len)); m_p2 = clampv(int'(phi2_len)); m_d = clampv(int'(dead_len));
      end else begin
        m_run = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    int per, s2;
    @(posedge clk);
    model_step();
    #1;
    per = m_p1 + m_p2 + 2 * m_d;
    s2  = m_p1 + m_d;
    check("phi1", phi1, (m_run == 1 && m_pos < m_p1) ? 1 : 0);
    check("phi2", phi2, (m_run == 1 && m_pos >= s2 && m_pos < s2 + m_p2) ? 1 : 0);
    check("busy", busy, m_run);
    check("period_done", period_done, (m_run == 1 && m_pos == per - 1) ? 1 : 0);
    check("period_cnt", period_cnt, m_pcnt);
    check("no_overlap", phi1 & phi2, 0);
`ifdef NOVL_EARLY_PHASE_EN
    begin
      int e1, e2;
      e1 = (m_p1 > EL) ? m_p1 - EL : 1;
      e2 = (m_p2 > EL) ? m_p2 - EL : 1;
      check("phi1e", phi1e, (m_run == 1 && m_pos < e1) ? 1 : 0);
      check("phi2e", phi2e, (m_run == 1 && m_pos >= s2 && m_pos < s2 + e2) ? 1 : 0);
    end
`endif
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_len(input int a, input int b, input int c);
    phi1_len = 8'(a); phi2_len = 8'(b); dead_len = 8'(c);
  endtask

  typedef struct {
    int p1, p2, d;
    int n;
    int exp_cnt, exp_p1, exp_p2, exp_done;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c1, c2, nd;
    rst_n = 1'b0; enable = 1'b0;
    set_len(0, 0, 0);
    #2;

    // n = edges after enable rises; first edge enters phi1.
    vecs[0] = '{p1: 4, p2: 3, d: 2, n: 34, exp_cnt: 3, exp_p1: 13, exp_p2: 9,  exp_done: 3};
    vecs[1] = '{p1: 0, p2: 0, d: 0, n: 13, exp_cnt: 3, exp_p1: 4,  exp_p2: 3,  exp_done: 3};
    vecs[2] = '{p1: 2, p2: 5, d: 3, n: 27, exp_cnt: 2, exp_p1: 5,  exp_p2: 10, exp_done: 2};
    vecs[3] = '{p1: 7, p2: 1, d: 1, n: 21, exp_cnt: 2, exp_p1: 15, exp_p2: 2,  exp_done: 2};

    do_reset();
    check("rst_phi1", phi1, 0);
    check("rst_phi2", phi2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", period_done, 0);
    check("rst_cnt", period_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      set_len(vecs[i].p1, vecs[i].p2, vecs[i].d);
      enable = 1'b1;
      c1 = 0; c2 = 0; nd = 0;
      for (int c = 0; c < vecs[i].n; c++) begin
        tick();
        c1 += int'(phi1); c2 += int'(phi2); nd += int'(period_done);
      end
      check("vec_period_cnt", period_cnt, vecs[i].exp_cnt);
      check("vec_phi1_cycles", c1, vecs[i].exp_p1);
      check("vec_phi2_cycles", c2, vecs[i].exp_p2);
      check("vec_done_pulses", nd, vecs[i].exp_done);
    end

    // Graceful stop: enable dropped in cycle 2 of phi2.
    do_reset();
    set_len(5, 5, 1);
    enable = 1'b1;
    c2 = 0;
    for (int c = 0; c < 8; c++) begin tick(); c2 += int'(phi2); end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); c2 += int'(phi2); end
    check("stop_busy_in_dead21", busy, 1);
    check("stop_done_in_dead21", period_done, 1);
    tick();
    c2 += int'(phi2);
    check("stop_busy_idle", busy, 0);
    check("stop_period_cnt", period_cnt, 1);
    check("stop_phi2_cycles", c2, 5);

    // Mid-period length change applies only to the next period.
    do_reset();
    set_len(4, 3, 2);
    enable = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    phi1_len = 8'd7;
    c1 = 0;
    for (int c = 0; c < 4; c++) begin tick(); c1 += int'(phi1); end
    check("cfg_rest_of_period_phi1", c1, 0);
    c1 = 0;
    for (int c = 0; c < 12; c++) begin tick(); c1 += int'(phi1); end
    check("cfg_next_phi1_cycles", c1, 7);

    // Reset mid-phi1 with enable held high.
    do_reset();
    set_len(4, 3, 2);
    enable = 1'b1;
    for (int c = 0; c < 13; c++) tick();
    check("pre_rst_phi1", phi1, 1);
    check("pre_rst_cnt", period_cnt, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_phi1", phi1, 0);
    check("midrst_cnt", period_cnt, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_phi1", phi1, 1);
    tick();
    check("post_rst_phi1_hold", phi1, 1);

    // Randomized run against the model.
    do_reset();
    set_len(2, 2, 1);
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)
        set_len($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
